pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 14 +
 rtl/pipe_stage_reg_slot.sv | 70 +++++++
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared CPU pipeline definitions: exception/NOP encodings and the
// occupancy encoding of the skid-buffered pipeline stage register.
package pipe_stage_reg_pkg;

  localparam int          EXC_NONE  = 0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// stage_slot: one pipeline entry (pc, instr, data, exc, bd, valid).
// Priority: reset, then flush, then load, then clear.
module stage_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int EXC_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [31:0]       flush_pc,
  input  logic              load,
  input  logic              clear,
  input  logic [31:0]       d_pc,
  input  logic [31:0]       d_instr,
  input  logic [DATA_W-1:0] d_data,
  input  logic [EXC_W-1:0]  d_exc,
  input  logic              d_bd,
  output logic              q_valid,
  output logic [31:0]       q_pc,
  output logic [31:0]       q_instr,
  output logic [DATA_W-1:0] q_data,
  output logic [EXC_W-1:0]  q_exc,
  output logic              q_bd
);

  logic              valid_reg;
  logic [31:0]       pc_reg;
  logic [31:0]       instr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [EXC_W-1:0]  exc_reg;
  logic              bd_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= NOP_INSTR;
      data_reg  <= '0;
      exc_reg   <= EXC_W'(EXC_NONE);
      bd_reg    <= 1'b0;
    end else if (flush) begin
      // pc takes the handler target so the stage shows where fetch restarts
      valid_reg <= 1'b0;
      pc_reg    <= flush_pc;
      instr_reg <= NOP_INSTR;
      data_reg  <= '0;
      exc_reg   <= EXC_W'(EXC_NONE);
      bd_reg    <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= d_pc;
      instr_reg <= d_instr;
      data_reg  <= d_data;
      exc_reg   <= d_exc;
      bd_reg    <= d_bd;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  assign q_valid = valid_reg;
  assign q_pc    = pc_reg;
  assign q_instr = instr_reg;
  assign q_data  = data_reg;
  assign q_exc   = exc_reg;
  assign q_bd    = bd_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry
// skid buffer (registered in_ready), flush-to-handler and exception merge.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int EXC_W  = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  loc_exc,
  input  logic              in_bd,
  input  logic              flush,
  input  logic [31:0]       flush_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd
);

  logic              take_in, take_out;
  logic [EXC_W-1:0]  merged_exc;
  logic              main_load, main_clear, main_valid, main_bd, main_d_bd;
  logic [31:0]       main_pc, main_instr, main_d_pc, main_d_instr;
  logic [DATA_W-1:0] main_data, main_d_data;
  logic [EXC_W-1:0]  main_exc, main_d_exc;

  assign take_in  = in_valid && in_ready;
  assign take_out = main_valid && out_ready;
  // the earliest exception in program order wins
  assign merged_exc = (in_exc != EXC_W'(EXC_NONE)) ? in_exc : loc_exc;

  stage_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_main (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .load(main_load), .clear(main_clear),
    .d_pc(main_d_pc), .d_instr(main_d_instr), .d_data(main_d_data),
    .d_exc(main_d_exc), .d_bd(main_d_bd),
    .q_valid(main_valid), .q_pc(main_pc), .q_instr(main_instr),
    .q_data(main_data), .q_exc(main_exc), .q_bd(main_bd)
  );

  assign out_valid = main_valid;
  assign out_pc    = main_pc;
  assign out_instr = main_valid ? main_instr : NOP_INSTR;
  assign out_data  = main_valid ? main_data : '0;
  assign out_exc   = main_valid ? main_exc : EXC_W'(EXC_NONE);
  assign out_bd    = main_valid && main_bd;

  generate
    if (SKID != 0) begin : g_skid
      occ_e              state_reg, state_next;
      logic              in_ready_reg;
      logic              skid_load, skid_clear, main_from_skid;
      logic              skid_valid, skid_bd;
      logic [31:0]       skid_pc, skid_instr;
      logic [DATA_W-1:0] skid_data;
      logic [EXC_W-1:0]  skid_exc;

      stage_slot #(.DATA_W(DATA_W), .EXC_W(EXC_W)) u_skid (
        .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
        .load(skid_load), .clear(skid_clear),
        .d_pc(in_pc), .d_instr(in_instr), .d_data(in_data),
        .d_exc(merged_exc), .d_bd(in_bd),
        .q_valid(skid_valid), .q_pc(skid_pc), .q_instr(skid_instr),
        .q_data(skid_data), .q_exc(skid_exc), .q_bd(skid_bd)
      );

      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg    <= OCC_EMPTY;
          in_ready_reg <= 1'b1;
        end else begin
          state_reg    <= state_next;
          in_ready_reg <= (state_next != OCC_FULL);
        end
      end

      always_comb begin
        state_next = state_reg;
        if (flush) begin
          state_next = OCC_EMPTY;
        end else begin
          case (state_reg)
            OCC_EMPTY: if (take_in) state_next = OCC_ONE;
            OCC_ONE: begin
              if (take_in && !take_out)      state_next = OCC_FULL;
              else if (!take_in && take_out) state_next = OCC_EMPTY;
            end
            OCC_FULL:  if (take_out) state_next = OCC_ONE;
            default:   state_next = OCC_EMPTY;
          endcase
        end
      end

      always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (!flush) begin
          case (state_reg)
            OCC_EMPTY: main_load = take_in;
            OCC_ONE: begin
              if (take_in && !take_out) skid_load  = 1'b1;
              else if (take_in)         main_load  = 1'b1;
              else if (take_out)        main_clear = 1'b1;
            end
            OCC_FULL: begin
              if (take_out && skid_valid) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clear     = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end

      assign in_ready     = in_ready_reg;
      assign main_d_pc    = main_from_skid ? skid_pc    : in_pc;
      assign main_d_instr = main_from_skid ? skid_instr : in_instr;
      assign main_d_data  = main_from_skid ? skid_data  : in_data;
      assign main_d_exc   = main_from_skid ? skid_exc   : merged_exc;
      assign main_d_bd    = main_from_skid ? skid_bd    : in_bd;
    end else begin : g_single
      // a simultaneous pop and push simply overwrites the single entry
      assign in_ready     = !main_valid || out_ready;
      assign main_load    = take_in && !flush;
      assign main_clear   = take_out && !take_in;
      assign main_d_pc    = in_pc;
      assign main_d_instr = in_instr;
      assign main_d_data  = in_data;
      assign main_d_exc   = merged_exc;
      assign main_d_bd    = in_bd;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: drivers queue expected entries on accepted transfers,
// per-DUT monitors pop and compare on every transfer-out (SKID=1 and SKID=0).
module tb_pipe_stage_reg;

  typedef struct packed {
    logic        reset;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [95:0] data;
    logic [4:0]  exc;
    logic [4:0]  loc;
    logic        bd;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_ready;
  } drv_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [95:0] data;
    logic [4:0]  exc;
    logic        bd;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  drv_t da, db;
  logic        a_in_ready, a_out_valid, a_out_bd, b_in_ready, b_out_valid, b_out_bd;
  logic [31:0] a_out_pc, a_out_instr, b_out_pc, b_out_instr;
  logic [95:0] a_out_data, b_out_data;
  logic [4:0]  a_out_exc, b_out_exc;

  ent_t qa[$];
  ent_t qb[$];
  int n_pass  = 0;
  int n_total = 0;

  pipe_stage_reg #(.DATA_W(96), .EXC_W(5), .SKID(1)) dut_a (
    .clk(clk), .reset(da.reset), .in_valid(da.valid), .in_ready(a_in_ready),
    .in_pc(da.pc), .in_instr(da.instr), .in_data(da.data), .in_exc(da.exc),
    .loc_exc(da.loc), .in_bd(da.bd), .flush(da.flush), .flush_pc(da.flush_pc),
    .out_valid(a_out_valid), .out_ready(da.out_ready), .out_pc(a_out_pc),
    .out_instr(a_out_instr), .out_data(a_out_data), .out_exc(a_out_exc), .out_bd(a_out_bd)
  );

  pipe_stage_reg #(.DATA_W(96), .EXC_W(5), .SKID(0)) dut_b (
    .clk(clk), .reset(db.reset), .in_valid(db.valid), .in_ready(b_in_ready),
    .in_pc(db.pc), .in_instr(db.instr), .in_data(db.data), .in_exc(db.exc),
    .loc_exc(db.loc), .in_bd(db.bd), .flush(db.flush), .flush_pc(db.flush_pc),
    .out_valid(b_out_valid), .out_ready(db.out_ready), .out_pc(b_out_pc),
    .out_instr(b_out_instr), .out_data(b_out_data), .out_exc(b_out_exc), .out_bd(b_out_bd)
  );

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [95:0] data, input logic [4:0] exc, input logic bd);
    ent_t e;
    e.pc = pc; e.instr = instr; e.data = data; e.exc = exc; e.bd = bd;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one entry on the selected DUT and expect it to be accepted.
  task automatic push(input bit use_b, input logic [31:0] pc, input logic [31:0] instr,
                      input logic [95:0] data, input logic [4:0] exc, input logic [4:0] loc,
                      input logic bd, input logic [4:0] exp_exc);
    drv_t d;
    logic rdy;
    step();
    d = use_b ? db : da;
    d.valid = 1'b1; d.pc = pc; d.instr = instr; d.data = data;
    d.exc = exc; d.loc = loc; d.bd = bd;
    if (use_b) db = d; else da = d;
    @(negedge clk);
    rdy = use_b ? b_in_ready : a_in_ready;
    chk(use_b ? "b_accept" : "a_accept", 192'(rdy), 192'd1);
    if (rdy) begin
      if (use_b) qb.push_back(mk(pc, instr, data, exp_exc, bd));
      else       qa.push_back(mk(pc, instr, data, exp_exc, bd));
    end
  endtask

  task automatic rand_phase(input bit use_b, input int n, input logic [31:0] base);
    drv_t d;
    logic acc;
    for (int i = 0; i < n; i++) begin
      step();
      d = use_b ? db : da;
      d.valid     = 1'($urandom_range(0, 1));
      d.out_ready = 1'($urandom_range(0, 1));
      d.pc        = base + 32'(i * 4);
      d.instr     = $urandom;
      d.data      = {$urandom, $urandom, $urandom};
      d.exc       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      d.loc       = 5'($urandom_range(0, 31));
      d.bd        = 1'($urandom_range(0, 1));
      if (use_b) db = d; else da = d;
      @(negedge clk);
      acc = d.valid && (use_b ? b_in_ready : a_in_ready);
      if (acc) begin
        if (use_b) qb.push_back(mk(d.pc, d.instr, d.data, (d.exc != 0) ? d.exc : d.loc, d.bd));
        else       qa.push_back(mk(d.pc, d.instr, d.data, (d.exc != 0) ? d.exc : d.loc, d.bd));
      end
    end
    step();
    d = use_b ? db : da;
    d.valid = 1'b0; d.out_ready = 1'b1;
    if (use_b) db = d; else da = d;
    repeat (4) step();
    @(negedge clk);
    chk(use_b ? "b_drained" : "a_drained", 192'(use_b ? qb.size() : qa.size()), 192'd0);
  endtask

  always @(negedge clk) begin : mon_a
    ent_t e;
    if (!da.reset) begin
      if (a_out_valid && da.out_ready) begin
        chk("a_pending", 192'(qa.size() != 0), 192'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          $display("A out pc=%h instr=%h exc=%0d bd=%0b", a_out_pc, a_out_instr, a_out_exc, a_out_bd);
          chk("a_entry", {a_out_pc, a_out_instr, a_out_data, a_out_exc, a_out_bd},
              {e.pc, e.instr, e.data, e.exc, e.bd});
        end
      end else if (!a_out_valid) begin
        chk("a_bubble", {a_out_instr, a_out_data, a_out_exc, a_out_bd}, 192'd0);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    ent_t e;
    if (!db.reset) begin
      if (b_out_valid && db.out_ready) begin
        chk("b_pending", 192'(qb.size() != 0), 192'd1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          $display("B out pc=%h instr=%h exc=%0d bd=%0b", b_out_pc, b_out_instr, b_out_exc, b_out_bd);
          chk("b_entry", {b_out_pc, b_out_instr, b_out_data, b_out_exc, b_out_bd},
              {e.pc, e.instr, e.data, e.exc, e.bd});
        end
      end else if (!b_out_valid) begin
        chk("b_bubble", {b_out_instr, b_out_data, b_out_exc, b_out_bd}, 192'd0);
      end
    end
  end

  initial begin
    da = '0; db = '0;
    da.reset = 1'b1; db.reset = 1'b1;
    repeat (2) step();
    da.reset = 1'b0;
    @(negedge clk);
    chk("a_rst_valid", 192'(a_out_valid), 192'd0);
    chk("a_rst_pc", 192'(a_out_pc), 192'd0);
    chk("a_rst_ready", 192'(a_in_ready), 192'd1);

    // Fill to FULL with out_ready low; exception merge on A (loc) and B (in wins)
    push(0, 32'h3000, 32'h2401_0001, 96'hA, 5'd0, 5'd4, 1'b1, 5'd4);
    push(0, 32'h3004, 32'h8C22_0004, 96'hB, 5'd5, 5'd4, 1'b0, 5'd5);
    step();
    da.pc = 32'h3008; da.instr = 32'hAC23_0008; da.exc = 5'd0; da.loc = 5'd0;
    @(negedge clk);
    chk("a_full_ready", 192'(a_in_ready), 192'd0);
    chk("a_full_valid", 192'(a_out_valid), 192'd1);
    chk("a_full_pc", 192'(a_out_pc), 192'h3000);
    step();
    @(negedge clk);
    chk("a_full_hold_ready", 192'(a_in_ready), 192'd0);
    step();
    da.valid = 1'b0; da.out_ready = 1'b1;
    repeat (2) step();
    @(negedge clk);
    chk("a_empty_valid", 192'(a_out_valid), 192'd0);
    chk("a_hold_pc", 192'(a_out_pc), 192'h3004);
    chk("a_empty_ready", 192'(a_in_ready), 192'd1);
    chk("a_q_empty", 192'(qa.size()), 192'd0);

    // Flush while FULL with a pending input
    da.out_ready = 1'b0;
    push(0, 32'h3010, 32'h0000_1010, 96'hD, 5'd0, 5'd0, 1'b0, 5'd0);
    push(0, 32'h3014, 32'h0000_1014, 96'hE, 5'd3, 5'd0, 1'b1, 5'd3);
    step();
    da.pc = 32'h3018; da.flush = 1'b1; da.flush_pc = 32'h4180;
    step();
    da.flush = 1'b0; da.valid = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("a_flush_valid", 192'(a_out_valid), 192'd0);
    chk("a_flush_pc", 192'(a_out_pc), 192'h4180);
    chk("a_flush_instr", 192'(a_out_instr), 192'd0);
    chk("a_flush_ready", 192'(a_in_ready), 192'd1);
    da.out_ready = 1'b1;
    repeat (3) step();

    // Flush beats a transfer-in that would otherwise be accepted
    da.valid = 1'b1; da.pc = 32'h301C; da.instr = 32'h1111_0000;
    da.flush = 1'b1; da.flush_pc = 32'h4200;
    step();
    da.valid = 1'b0; da.flush = 1'b0;
    @(negedge clk);
    chk("a_flush_in_valid", 192'(a_out_valid), 192'd0);
    chk("a_flush_in_pc", 192'(a_out_pc), 192'h4200);

    // Reset mid-FULL with a pending input
    da.out_ready = 1'b0;
    push(0, 32'h3020, 32'h0000_3020, 96'h1, 5'd0, 5'd2, 1'b0, 5'd2);
    push(0, 32'h3024, 32'h0000_3024, 96'h2, 5'd0, 5'd0, 1'b0, 5'd0);
    step();
    da.pc = 32'h3000; da.reset = 1'b1;
    step();
    da.reset = 1'b0; da.valid = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("a_rst2_valid", 192'(a_out_valid), 192'd0);
    chk("a_rst2_pc", 192'(a_out_pc), 192'd0);
    chk("a_rst2_ready", 192'(a_in_ready), 192'd1);

    rand_phase(0, 600, 32'h0000_5000);

    // SKID=0 single-entry stage
    db.reset = 1'b0;
    @(negedge clk);
    chk("b_rst_valid", 192'(b_out_valid), 192'd0);
    chk("b_rst_pc", 192'(b_out_pc), 192'd0);
    chk("b_rst_ready", 192'(b_in_ready), 192'd1);
    db.out_ready = 1'b1;
    push(1, 32'h3000, 32'h2401_0001, 96'h10, 5'd0, 5'd4, 1'b0, 5'd4);
    push(1, 32'h3004, 32'h2401_0002, 96'h11, 5'd5, 5'd4, 1'b1, 5'd5);
    chk("b_follow_pc", 192'(b_out_pc), 192'h3000);
    push(1, 32'h3008, 32'h2401_0003, 96'h12, 5'd0, 5'd0, 1'b0, 5'd0);
    chk("b_follow_pc2", 192'(b_out_pc), 192'h3004);
    step();
    db.pc = 32'h300C; db.out_ready = 1'b0;
    @(negedge clk);
    chk("b_stall_ready", 192'(b_in_ready), 192'd0);
    step();
    db.valid = 1'b0; db.out_ready = 1'b1;
    repeat (2) step();

    rand_phase(1, 600, 32'h0000_9000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
